mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Iterative HI/LO multiplier executing MULT/MULTU; the responder side of the multiplier start/valid handshake.
- Accepts a start pulse from the Execute stage and computes the product over several cycles.
- Holds pve low while busy, so the hazard logic stalls F/D and flushes E.
- Raises pve when HI/LO hold the new product. Also owns the HI/LO registers and their MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH split into hi/lo.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
multstartE  input  1  start pulse, sampled on rising edge
multsignedE  input  1  1 = MULT (two's complement), 0 = MULTU
srcaE  input  WIDTH  multiplicand, sampled with multstartE
srcbE  input  WIDTH  multiplier, sampled with multstartE
hiwe  input  1  MTHI write enable
lowe  input  1  MTLO write enable
hilowd  input  WIDTH  MTHI/MTLO write data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
pve  output  1  product valid / unit idle; low while an operation is pending
busy  output  1  high in CALC or FIX

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, pve=1, busy=0, iteration counter=0, internal accumulators=0. Reset mid-operation aborts it; nothing is retained.
- FSM states: IDLE, CALC, FIX.
- IDLE, multstartE=1 at edge k:
  - Latch |srcaE| and |srcbE|: magnitudes when multsignedE=1, raw values otherwise.
  - Latch neg = multsignedE & (srcaE[MSB] ^ srcbE[MSB]).
  - Clear accumulator and counter; pve<=0; go to CALC.
- CALC, radix-2 shift-add, one multiplier bit per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper accumulator half; shift the {carry, acc} pair right by 1.
  - Counter increments. After the WIDTH-th step (edge k+WIDTH), go to FIX.
- FIX, edge k+WIDTH+1:
  - {hi,lo} <= neg ? -acc : acc, computed as a 2*WIDTH-bit two's complement.
  - pve<=1; go to IDLE.
- Latency: pve falls on edge k and rises on edge k+WIDTH+1 (33 cycles for WIDTH=32). hi/lo keep their previous values until FIX.
- pve is a level, not a pulse: it stays 1 in IDLE until the next accepted start.
- multstartE while busy: restarts from the new operands; the old operation is discarded and pve stays 0. The hazard unit never issues this, but the behaviour is defined.
- MTHI/MTLO:
  - hiwe/lowe write hilowd into hi/lo only when busy=0.
  - While busy, writes are ignored.
  - Write and start on the same IDLE edge: the write takes effect; FIX later overwrites both registers.
- Width rule: -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits; no special case is needed.

Optional Feature:
- Macro MULT_RADIX4_EN.
- Defined: CALC consumes 2 multiplier bits per cycle, adding 0, 1×, 2× or 3× the multiplicand. The 3× term is precomputed at start with a WIDTH+2-bit adder. CALC lasts WIDTH/2 cycles and pve rises at edge k+WIDTH/2+1 (17 cycles). WIDTH must be even.
- Not defined: radix-2 as described above. Results are bit-identical in both builds; only latency differs.

Decomposition:
- Package mult_pkg: state enum (IDLE, CALC, FIX), MULT_WIDTH=32, the counter width constant (clog2 of the step count), and step-count constants for radix-2 and radix-4.
- One sub-module, mult_step: a combinational single-iteration step (add plus shift) taking accumulator, multiplier bits and multiplicand, returning the next accumulator. It is selected for radix-2 or radix-4 under MULT_RADIX4_EN.
- mult_unit keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
1. Reset release, no activity -> hi=0, lo=0, pve=1, busy=0. Assert reset_n=0 mid-CALC -> same values immediately, without waiting for a clock edge.
2. MULTU 0xFFFFFFFF × 0x00000001 -> pve low for exactly 33 cycles (17 with MULT_RADIX4_EN); then hi=0x00000000, lo=0xFFFFFFFF.
3. MULT 0xFFFFFFFF × 0x00000001 (-1×1) -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
4. MULT 0x00012345 × 0xFFFFFFFE (74565×-2) -> hi=0xFFFFFFFF, lo=0xFFFDB976. hi/lo hold their prior values on every cycle until the FIX edge.
5. Registers preloaded with hi=0x11111111; hiwe=1 with hilowd=0xAAAAAAAA while busy -> ignored, final hi is the product. Same write in IDLE -> hi=0xAAAAAAAA next cycle, lo unchanged.
6. Start 3×5, then re-pulse multstartE with 7×6 at cycle 10 of CALC -> pve stays 0, rises 33 cycles after the second start, and {hi,lo}=42.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiplier.
// MULT_RADIX4_EN selects two multiplier bits per CALC cycle.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int STEPS_R2 = MULT_WIDTH;
  localparam int STEPS_R4 = MULT_WIDTH / 2;

`ifdef MULT_RADIX4_EN
  localparam int STEP_BITS = 2;
  localparam int MULT_STEPS = STEPS_R4;
`else
  localparam int STEP_BITS = 1;
  localparam int MULT_STEPS = STEPS_R2;
`endif

  localparam int CNT_W = $clog2(MULT_STEPS);

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration of the unsigned multiplier.
// MULT_RADIX4_EN: consumes two multiplier bits using a precomputed 3x term.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [STEP_BITS-1:0] mbits,
`ifdef MULT_RADIX4_EN
  input  logic [WIDTH+1:0]     mcand3,
`endif
  input  logic [WIDTH-1:0]     mcand,
  output logic [2*WIDTH-1:0]   accNext
);

  localparam int AW = 2 * WIDTH;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

  // Pick 0/1x/2x/3x, add into the upper half, shift by two.
  always_comb begin
    addend = '0;
    unique case (mbits)
      2'd0: addend = '0;
      2'd1: addend = {2'b00, mcand};
      2'd2: addend = {1'b0, mcand, 1'b0};
      2'd3: addend = mcand3;
      default: addend = '0;
    endcase
    sum = {2'b00, acc[AW-1:WIDTH]} + addend;
    accNext = AW'({sum, acc[WIDTH-1:0]} >> 2);
  end
`else
  logic [WIDTH:0] sum;

  // Conditionally add the multiplicand, shift carry+acc by one.
  always_comb begin
    sum = {1'b0, acc[AW-1:WIDTH]};
    if (mbits[0]) sum = sum + {1'b0, mcand};
    accNext = AW'({sum, acc[WIDTH-1:0]} >> 1);
  end
`endif

endmodule

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU unit owning HI/LO; pve is low while busy.
// MULT_RADIX4_EN halves CALC length; results are identical.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             multstartE,
  input  logic             multsignedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] hilowd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             pve,
  output logic             busy
);

  localparam int STEPS =
    (WIDTH == MULT_WIDTH) ? MULT_STEPS : WIDTH / STEP_BITS;
  localparam int CW =
    (WIDTH == MULT_WIDTH) ? CNT_W : $clog2(STEPS);

  state_t state;
  state_t stateNext;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] result;
  logic               neg;
  logic               negIn;
  logic               lastStep;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] mcand3;
  logic [WIDTH+1:0] mcand3In;
  assign mcand3In = {2'b00, magA} + {1'b0, magA, 1'b0};
`endif

  assign magA = (multsignedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign magB = (multsignedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
  assign negIn = multsignedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
  assign lastStep = (cnt == CW'(STEPS - 1));
  assign result = neg ? -acc : acc;
  assign pve = (state == IDLE);
  assign busy = ~pve;

  mult_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .acc    (acc),
    .mbits  (mplier[STEP_BITS-1:0]),
`ifdef MULT_RADIX4_EN
    .mcand3 (mcand3),
`endif
    .mcand  (mcand),
    .accNext(accNext)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next state; a start in any state (re)launches CALC.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (multstartE) stateNext = CALC;
      CALC: begin
        if (multstartE)    stateNext = CALC;
        else if (lastStep) stateNext = FIX;
      end
      FIX: stateNext = multstartE ? CALC : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch and shift-add datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
`ifdef MULT_RADIX4_EN
      mcand3 <= '0;
`endif
    end else if (multstartE) begin
      mcand  <= magA;
      mplier <= magB;
      neg    <= negIn;
      acc    <= '0;
      cnt    <= '0;
`ifdef MULT_RADIX4_EN
      mcand3 <= mcand3In;
`endif
    end else if (state == CALC) begin
      acc    <= accNext;
      mplier <= mplier >> STEP_BITS;
      cnt    <= cnt + 1'b1;
    end
  end

  // HI/LO: product on FIX, MTHI/MTLO only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !multstartE) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end else if (!busy) begin
      if (hiwe) hi <= hilowd;
      if (lowe) lo <= hilowd;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Randomized self-checking bench for mult_unit.
// Honours MULT_RADIX4_EN for the expected latency.
module tb_mult_unit;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;
`ifdef MULT_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         multstartE = 1'b0;
  logic         multsignedE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         hiwe = 1'b0;
  logic         lowe = 1'b0;
  logic [W-1:0] hilowd = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         pve;
  logic         busy;

  int nVec = 0;
  int nErr = 0;

  mult_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .multstartE (multstartE),
    .multsignedE(multsignedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hiwe       (hiwe),
    .lowe       (lowe),
    .hilowd     (hilowd),
    .hi         (hi),
    .lo         (lo),
    .pve        (pve),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] refProd(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic startOp(input logic s,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    multsignedE = s;
    srcaE = a;
    srcbE = b;
    multstartE = 1'b1;
    tick();
    multstartE = 1'b0;
    multsignedE = 1'($urandom);
    srcaE = $urandom;
    srcbE = $urandom;
  endtask

  task automatic waitDone(output int n,
                          output logic holdBad,
                          input logic [63:0] prev);
    n = 0;
    holdBad = 1'b0;
    while (!pve && n < 200) begin
      if ({hi, lo} !== prev) holdBad = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic runOp(input string tag,
                       input logic s,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic wrBusy);
    logic [63:0] prev;
    logic [63:0] exp;
    logic        hb;
    int          n;
    prev = {hi, lo};
    exp = refProd(s, a, b);
    startOp(s, a, b);
    if (wrBusy) begin
      hiwe = 1'b1;
      lowe = 1'b1;
      hilowd = 32'hAAAA_AAAA;
    end
    waitDone(n, hb, prev);
    hiwe = 1'b0;
    lowe = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    check({tag, "_hold"}, 64'(hb), 64'd0);
    check({tag, "_prod"}, {hi, lo}, exp);
  endtask

  logic [W-1:0] corner [6];
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] prevLo;
  logic [63:0]  prev;
  logic         hb;
  logic         pveSeen;
  int           n;

  initial begin
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'h0001_2345;

    // Reset state
    tick();
    tick();
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_pve", 64'(pve), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_hilo", {hi, lo}, 64'd0);
    check("idle_pve", 64'(pve), 64'd1);

    // Directed cases
    runOp("multu_ff_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    runOp("mult_m1_1", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    runOp("mult_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    runOp("mult_x_m2", 1'b1, 32'h0001_2345, 32'hFFFF_FFFE, 1'b0);
    check("x_m2_abs", {hi, lo}, 64'hFFFF_FFFF_FFFD_B976);

    // MTHI in idle, then ignored while busy
    hiwe = 1'b1;
    hilowd = 32'h1111_1111;
    tick();
    hiwe = 1'b0;
    check("mthi_pre", 64'(hi), 64'h1111_1111);
    runOp("busy_wr", 1'b0, 32'h0000_1234, 32'h0000_5678, 1'b1);
    prevLo = lo;
    hiwe = 1'b1;
    hilowd = 32'hAAAA_AAAA;
    tick();
    hiwe = 1'b0;
    check("mthi_idle", 64'(hi), 64'hAAAA_AAAA);
    check("mthi_lo_keep", 64'(lo), 64'(prevLo));

    // Write and start on the same edge
    hiwe = 1'b1;
    lowe = 1'b1;
    hilowd = 32'h5555_5555;
    startOp(1'b1, 32'hFFFF_FFF9, 32'h0000_0003);
    hiwe = 1'b0;
    lowe = 1'b0;
    check("wr_start_hilo", {hi, lo}, 64'h5555_5555_5555_5555);
    waitDone(n, hb, 64'h5555_5555_5555_5555);
    check("wr_start_lat", 64'(n), 64'(LAT));
    check("wr_start_hold", 64'(hb), 64'd0);
    check("wr_start_prod", {hi, lo}, 64'(-21));

    // Restart mid-CALC
    prev = {hi, lo};
    pveSeen = 1'b0;
    startOp(1'b0, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (pve) pveSeen = 1'b1;
      tick();
    end
    startOp(1'b0, 32'd7, 32'd6);
    waitDone(n, hb, prev);
    check("restart_pve", 64'(pveSeen), 64'd0);
    check("restart_lat", 64'(n), 64'(LAT));
    check("restart_hold", 64'(hb), 64'd0);
    check("restart_prod", {hi, lo}, 64'd42);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)]
                                       : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)]
                                       : $urandom;
      runOp($sformatf("rnd%0d", i), 1'($urandom), ra, rb, 1'b0);
    end

    // Asynchronous reset mid-CALC
    startOp(1'b1, 32'h0012_3456, 32'hFFFF_FFF9);
    for (int i = 0; i < 5; i++) tick();
    check("pre_arst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_pve", 64'(pve), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    runOp("post_arst", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
